// File: rtl/dr_pkg.sv
// Shared types and constants for the clocked dual-rail adder.
package dr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        DONE,
        NULL,
        ERR
    } state_t;

    localparam logic [1:0] DR_SPACER  = 2'b00;
    localparam logic [1:0] DR_ZERO    = 2'b01;
    localparam logic [1:0] DR_ONE     = 2'b10;
    localparam logic [1:0] DR_ILLEGAL = 2'b11;

    // Ceiling log2 with a floor of 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'(1) << (i - 1)) < 64'(v)) begin
                r = 32'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dr_cd_pdr.sv
// Combinational completion detector over a W-bit dual-rail vector.
module dr_cd_pdr
    import dr_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] x_1,
    input  logic [W-1:0] x_0,
    output logic         all_valid,
    output logic         all_spacer,
    output logic         any_illegal
);

    logic [1:0] rail;

    always_comb begin
        all_valid   = 1'b1;
        all_spacer  = 1'b1;
        any_illegal = 1'b0;
        rail        = DR_SPACER;
        for (int i = 0; i < int'(W); i++) begin
            rail = {x_1[i], x_0[i]};
            if (rail != DR_ZERO && rail != DR_ONE) begin
                all_valid = 1'b0;
            end
            if (rail != DR_SPACER) begin
                all_spacer = 1'b0;
            end
            if (rail == DR_ILLEGAL) begin
                any_illegal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dr_adder_sync_pdr.sv
// Clocked dual-rail adder/subtractor with four-phase go/done handshake,
// stable-completion qualification, illegal-codeword and timeout detection.
module dr_adder_sync_pdr
    import dr_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STABLE_CYC = 2,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned SUB_EN     = 1
) (
    input  logic             clk,
    input  logic             reset_not,
    input  logic             go,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] a_0,
    input  logic [WIDTH-1:0] b_1,
    input  logic [WIDTH-1:0] b_0,
    output logic [WIDTH:0]   s_1,
    output logic [WIDTH:0]   s_0,
    output logic             done,
    output logic             err
);

    localparam int unsigned SW        = WIDTH + 1;
    localparam int unsigned SCW       = clog2(STABLE_CYC + 1);
    localparam int unsigned TCW       = clog2(TIMEOUT + 1);
    localparam int unsigned STAB_LAST = (STABLE_CYC == 0) ? 0 : STABLE_CYC - 1;
    localparam int unsigned TMO_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_t           state;
    logic             go_meta;
    logic             go_sync;
    logic             go_sync_d;
    logic             go_rise;
    logic             sub_q;
    logic [SCW-1:0]   stab_cnt;
    logic [TCW-1:0]   tmo_cnt;
    logic             stab_last;
    logic             tmo_hit;
    logic             all_valid;
    logic             all_spacer;
    logic             any_illegal;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_c;

    dr_cd_pdr #(
        .W (2 * WIDTH)
    ) u_cd (
        .x_1         ({a_1, b_1}),
        .x_0         ({a_0, b_0}),
        .all_valid   (all_valid),
        .all_spacer  (all_spacer),
        .any_illegal (any_illegal)
    );

    // Two-flop synchroniser plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_not) begin
            go_meta   <= 1'b0;
            go_sync   <= 1'b0;
            go_sync_d <= 1'b0;
        end else begin
            go_meta   <= go;
            go_sync   <= go_meta;
            go_sync_d <= go_sync;
        end
    end

    assign go_rise   = go_sync & ~go_sync_d;
    assign stab_last = (stab_cnt == SCW'(STAB_LAST));
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == TCW'(TMO_LAST));

    // Rails decode to binary via the 1-rail; subtract is a + ~b + 1.
    always_comb begin
        b_eff = sub_q ? ~b_1 : b_1;
        sum_c = SW'(a_1) + SW'(b_eff) + SW'(sub_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_not) begin
            state    <= IDLE;
            s_1      <= '0;
            s_0      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            sub_q    <= 1'b0;
            stab_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_rise) begin
                        state    <= EVAL;
                        sub_q    <= (SUB_EN != 0) ? sub : 1'b0;
                        stab_cnt <= '0;
                        tmo_cnt  <= '0;
                    end
                end
                EVAL: begin
                    tmo_cnt  <= tmo_cnt + TCW'(1);
                    stab_cnt <= all_valid ? stab_cnt + SCW'(1) : '0;
                    // Errors take priority over a completion on the same cycle.
                    if (any_illegal || tmo_hit || !go_sync) begin
                        state <= ERR;
                        s_1   <= '0;
                        s_0   <= '0;
                        done  <= 1'b0;
                        err   <= 1'b1;
                    end else if (all_valid && stab_last) begin
                        state <= DONE;
                        s_1   <= sum_c;
                        s_0   <= ~sum_c;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!go_sync) begin
                        state    <= NULL;
                        s_1      <= '0;
                        s_0      <= '0;
                        stab_cnt <= '0;
                        tmo_cnt  <= '0;
                    end
                end
                NULL: begin
                    tmo_cnt  <= tmo_cnt + TCW'(1);
                    stab_cnt <= all_spacer ? stab_cnt + SCW'(1) : '0;
                    if (any_illegal || tmo_hit) begin
                        state <= ERR;
                        s_1   <= '0;
                        s_0   <= '0;
                        done  <= 1'b0;
                        err   <= 1'b1;
                    end else if (all_spacer && stab_last) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                ERR: begin
                    s_1  <= '0;
                    s_0  <= '0;
                    done <= 1'b0;
                    err  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dr_adder_sync_pdr.sv
// Scoreboard bench for dr_adder_sync_pdr: random and directed four-phase transactions.
module tb_dr_adder_sync_pdr;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic         is_err;
        logic [W:0]   s;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_not;
    logic         go;
    logic         sub;
    logic [W-1:0] a_1, a_0, b_1, b_0;
    logic [W:0]   s_1, s_0, nt_s_1, nt_s_0;
    logic         done, err, nt_done, nt_err;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    dr_adder_sync_pdr #(
        .WIDTH (W), .STABLE_CYC (2), .TIMEOUT (15), .SUB_EN (1)
    ) u_dut (
        .clk (clk), .reset_not (reset_not), .go (go), .sub (sub),
        .a_1 (a_1), .a_0 (a_0), .b_1 (b_1), .b_0 (b_0),
        .s_1 (s_1), .s_0 (s_0), .done (done), .err (err)
    );

    // Same stimulus, timeout disabled.
    dr_adder_sync_pdr #(
        .WIDTH (W), .STABLE_CYC (2), .TIMEOUT (0), .SUB_EN (1)
    ) u_dut_nt (
        .clk (clk), .reset_not (reset_not), .go (go), .sub (sub),
        .a_1 (a_1), .a_0 (a_0), .b_1 (b_1), .b_0 (b_0),
        .s_1 (nt_s_1), .s_0 (nt_s_0), .done (nt_done), .err (nt_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: add is plain a+b; subtract is a-b with bit W set when no borrow.
    function automatic logic [W:0] model(input int unsigned av, input int unsigned bv, input bit sv);
        int unsigned r;
        if (!sv) begin
            r = av + bv;
        end else begin
            r = ((av - bv) & 32'hFF) | ((av >= bv) ? 32'h100 : 32'h0);
        end
        return (W+1)'(r);
    endfunction

    task automatic drive_valid(input logic [W-1:0] av, input logic [W-1:0] bv);
        a_1 = av; a_0 = ~av;
        b_1 = bv; b_0 = ~bv;
    endtask

    task automatic drive_spacer();
        a_1 = '0; a_0 = '0; b_1 = '0; b_0 = '0;
    endtask

    task automatic drive_partial(input logic [W-1:0] av, input logic [W-1:0] bv);
        drive_valid(av, bv);
        b_1[0] = 1'b0;
        b_0[0] = 1'b0;
    endtask

    task automatic do_reset();
        go = 1'b0;
        reset_not = 1'b0;
        drive_spacer();
        tick();
        reset_not = 1'b1;
    endtask

    // Full four-phase cycle with valid operands presented before go.
    task automatic run_txn(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        int n;
        drive_valid(av, bv);
        sub = sv;
        sb.push_back({1'b0, model(av, bv, sv)});
        tick();
        go = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 40) begin tick(); n++; end
        check("go_to_done_latency", n, 5);
        drive_spacer();
        go = 1'b0;
        n = 0;
        while (done !== 1'b0 && n < 40) begin tick(); n++; end
        check("release_latency", n, 5);
        check("s_spacer_after_null", {s_1, s_0}, 0);
        tick();
    endtask

    // Monitor: every done or err rising edge consumes one scoreboard entry.
    initial begin : monitor
        logic       done_prev;
        logic       err_prev;
        exp_t       e;
        logic [W:0] inv;
        done_prev = 1'b0;
        err_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if ((done === 1'b1 && done_prev !== 1'b1) || (err === 1'b1 && err_prev !== 1'b1)) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output done=%b err=%b with empty scoreboard t=%0t",
                             done, err, $time);
                end else begin
                    e = sb.pop_front();
                    check("event_kind_is_err", err, e.is_err);
                    if (e.is_err) begin
                        check("err_done_low", done, 0);
                        check("err_s_spacer", {s_1, s_0}, 0);
                    end else begin
                        inv = ~e.s;
                        check("sum_s_1", s_1, e.s);
                        check("sum_s_0", s_0, inv);
                    end
                end
            end
            done_prev = done;
            err_prev  = err;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int         n;
        logic [W-1:0] av, bv;
        logic       sv;

        reset_not = 1'b0;
        go        = 1'b0;
        sub       = 1'b0;
        drive_spacer();
        tick(); tick(); tick();
        reset_not = 1'b1;
        check("reset_s_1", s_1, 0);
        check("reset_s_0", s_0, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);

        // Basic add, overflow add, borrowing subtract.
        run_txn(8'h5A, 8'h3C, 1'b0);
        run_txn(8'hFF, 8'h01, 1'b0);
        run_txn(8'h10, 8'h20, 1'b1);
        run_txn(8'h00, 8'h00, 1'b1);

        for (int i = 0; i < 10; i++) begin
            av = W'($urandom);
            bv = W'($urandom);
            sv = 1'($urandom_range(1));
            run_txn(av, bv, sv);
        end

        // Glitch: valid, partial, valid inside EVAL restarts qualification.
        av = W'($urandom);
        bv = W'($urandom);
        sub = 1'b0;
        drive_partial(av, bv);
        sb.push_back({1'b0, model(av, bv, 1'b0)});
        tick();
        go = 1'b1;
        tick(); tick(); tick();
        drive_valid(av, bv);
        tick();
        drive_partial(av, bv);
        tick();
        check("glitch_no_early_done", done, 0);
        drive_valid(av, bv);
        n = 5;
        while (done !== 1'b1 && n < 40) begin tick(); n++; end
        check("glitch_latency", n, 7);
        check("glitch_err_low", err, 0);
        drive_spacer();
        go = 1'b0;
        n = 0;
        while (done !== 1'b0 && n < 40) begin tick(); n++; end
        check("glitch_release_latency", n, 5);
        tick();

        // Reset while holding DONE, then a normal transaction.
        drive_valid(8'h33, 8'h44);
        sub = 1'b0;
        sb.push_back({1'b0, model(8'h33, 8'h44, 1'b0)});
        tick();
        go = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 40) begin tick(); n++; end
        check("pre_reset_latency", n, 5);
        tick();
        go = 1'b0;
        reset_not = 1'b0;
        tick();
        check("midreset_done", done, 0);
        check("midreset_s", {s_1, s_0}, 0);
        check("midreset_err", err, 0);
        reset_not = 1'b1;
        drive_spacer();
        tick();
        run_txn(8'h81, 8'h7F, 1'b0);

        // Illegal codeword in EVAL: sticky error, go ignored.
        drive_partial(8'hA5, 8'h5A);
        sub = 1'b0;
        sb.push_back({1'b1, (W+1)'(0)});
        tick();
        go = 1'b1;
        tick(); tick(); tick();
        check("illegal_no_err_yet", err, 0);
        a_1[3] = 1'b1;
        a_0[3] = 1'b1;
        tick();
        check("illegal_err", err, 1);
        check("illegal_done", done, 0);
        check("illegal_s", {s_1, s_0}, 0);
        go = 1'b0;
        drive_valid(8'h01, 8'h02);
        tick(); tick(); tick();
        go = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("illegal_sticky_err", err, 1);
        check("illegal_sticky_done", done, 0);
        do_reset();
        check("post_illegal_reset_err", err, 0);
        tick();

        // Timeout: b bit 0 never resolves.
        drive_partial(8'h12, 8'h34);
        sb.push_back({1'b1, (W+1)'(0)});
        tick();
        go = 1'b1;
        n = 0;
        while (err !== 1'b1 && n < 40) begin tick(); n++; end
        check("timeout_latency", n, 18);
        for (int i = 0; i < 10; i++) tick();
        check("no_timeout_build_err", nt_err, 0);
        check("no_timeout_build_done", nt_done, 0);
        check("no_timeout_build_s", {nt_s_1, nt_s_0}, 0);
        do_reset();
        tick();

        run_txn(8'hC3, 8'h3C, 1'b1);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
